// File: rtl/riscv_pkg.sv
// Shared RISC-V execute-stage types: M-extension operation encoding and decode helpers.
package riscv_pkg;

    // Encoding matches the funct3 field of the OP/OP-32 M-extension instructions.
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } muldiv_op_t;

    function automatic logic is_div(input muldiv_op_t op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    function automatic logic is_rem(input muldiv_op_t op);
        return op inside {MD_REM, MD_REMU};
    endfunction

    function automatic logic is_signed_a(input muldiv_op_t op);
        return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic is_signed_b(input muldiv_op_t op);
        return op inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration shared by multiply (shift-add) and divide (restoring subtract).
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN:0]   hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN:0]   hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    logic [XLEN:0] mul_sum;
    logic [XLEN:0] div_shift;
    logic [XLEN:0] div_diff;
    logic          borrow;

    // Multiply: lo holds the remaining multiplier bits; the sum shifts right into lo.
    assign mul_sum   = hi + {1'b0, (lo[0] ? opnd : '0)};
    // Divide: hi is the partial remainder, lo shifts the dividend out and quotient bits in.
    assign div_shift = {hi[XLEN-1:0], lo[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign borrow    = div_diff[XLEN];

    always_comb begin
        hi_nxt = '0;
        lo_nxt = '0;
        if (is_div) begin
            hi_nxt = borrow ? div_shift : div_diff;
            lo_nxt = {lo[XLEN-2:0], ~borrow};
        end else begin
            hi_nxt = {1'b0, mul_sum[XLEN:1]};
            lo_nxt = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit. Optional MULDIV_FAST_MUL_EN computes
// all multiplies in one cycle with a single signed multiplier; divides stay iterative.
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  muldiv_op_t      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} muldiv_state_t;

    muldiv_state_t state_q, state_d;

    muldiv_op_t      op_q;
    logic [XLEN-1:0] a_q, b_q, opnd_q, lo_q;
    logic [XLEN:0]   hi_q;
    logic [CNT_W-1:0] cnt_q;
    logic            neg_q, special_q;

    logic            a_neg, b_neg, div_zero, div_ovf, special;
    logic [XLEN-1:0] abs_a, abs_b, special_res;
    logic [XLEN:0]   hi_nxt;
    logic [XLEN-1:0] lo_nxt;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0] quo_s, rem_s, fix_result;

    // Handshakes: a transfer happens on a rising edge where valid && ready; the
    // producer holds its payload while valid && !ready, and flush overrides both.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);

    assign a_neg    = is_signed_a(op_q) & a_q[XLEN-1];
    assign b_neg    = is_signed_b(op_q) & b_q[XLEN-1];
    assign abs_a    = a_neg ? -a_q : a_q;
    assign abs_b    = b_neg ? -b_q : b_q;
    assign div_zero = is_div(op_q) && (b_q == '0);
    assign div_ovf  = (op_q inside {MD_DIV, MD_REM}) && (a_q == {1'b1, {(XLEN-1){1'b0}}})
                      && (b_q == '1);
    assign special  = div_zero | div_ovf;

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = is_rem(op_q) ? a_q : '1;
        else if (div_ovf)
            special_res = is_rem(op_q) ? '0 : a_q;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN-1:0] a_wide, b_wide, fast_prod;
    assign a_wide    = {{XLEN{a_neg}}, a_q};
    assign b_wide    = {{XLEN{b_neg}}, b_q};
    assign fast_prod = a_wide * b_wide;
`endif

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div (is_div(op_q)),
        .hi     (hi_q),
        .lo     (lo_q),
        .opnd   (opnd_q),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    // Magnitudes are produced by the datapath; sign is reapplied once here.
    assign prod   = {hi_q[XLEN-1:0], lo_q};
    assign prod_s = neg_q ? -prod : prod;
    assign quo_s  = neg_q ? -lo_q : lo_q;
    assign rem_s  = neg_q ? -hi_q[XLEN-1:0] : hi_q[XLEN-1:0];

    always_comb begin
        fix_result = quo_s;
        if (special_q)
            fix_result = lo_q;
        else if (op_q == MD_MUL)
            fix_result = prod_s[XLEN-1:0];
        else if (!is_div(op_q))
            fix_result = prod_s[2*XLEN-1:XLEN];
        else if (is_rem(op_q))
            fix_result = rem_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = S_PREP;
            S_PREP: begin
                if (special)
                    state_d = S_FIX;
`ifdef MULDIV_FAST_MUL_EN
                else if (!is_div(op_q))
                    state_d = S_FIX;
`endif
                else
                    state_d = S_CALC;
            end
            S_CALC: if (cnt_q == '0) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush)
            state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= MD_MUL;
            a_q        <= '0;
            b_q        <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            special_q  <= 1'b0;
            out_result <= '0;
        end else if (!flush) begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q <= in_op;
                        a_q  <= in_a;
                        b_q  <= in_b;
                    end
                end
                S_PREP: begin
                    cnt_q     <= CNT_W'(XLEN - 1);
                    opnd_q    <= abs_b;
                    hi_q      <= '0;
                    lo_q      <= abs_a;
                    special_q <= special;
                    neg_q     <= is_rem(op_q) ? a_neg : (a_neg ^ b_neg);
                    if (special) begin
                        lo_q  <= special_res;
                        neg_q <= 1'b0;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!is_div(op_q)) begin
                        hi_q  <= {1'b0, fast_prod[2*XLEN-1:XLEN]};
                        lo_q  <= fast_prod[XLEN-1:0];
                        neg_q <= 1'b0;
                    end
`endif
                end
                S_CALC: begin
                    hi_q  <= hi_nxt;
                    lo_q  <= lo_nxt;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                S_FIX: out_result <= fix_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit (XLEN=32): results, latency, backpressure, flush, reset.
module tb_muldiv_unit;
    import riscv_pkg::*;

    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = XLEN + 2;
`endif
    localparam int DIV_LAT = XLEN + 2;
    localparam int SPC_LAT = 2;
    localparam int NVEC    = 15;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    muldiv_op_t      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;

    int checks   = 0;
    int failures = 0;
    logic [XLEN-1:0] exp_q[$];

    typedef struct {
        muldiv_op_t      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
        int              lat;
    } vec_t;

    vec_t vecs[NVEC];

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver: called at a negedge; returns at the negedge after the accept edge.
    task automatic start_op(input muldiv_op_t op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready timeout: got 0 expected 1");
        end
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
    endtask

    // Counts rising edges after the accept edge until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL out_valid timeout: got 0 expected 1");
        end
    endtask

    task automatic collect(output logic [XLEN-1:0] res);
        res = out_result;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input muldiv_op_t op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int exp_lat);
        int              lat;
        logic [XLEN-1:0] res;
        logic [XLEN-1:0] want;
        exp_q.push_back(exp);
        start_op(op, a, b);
        wait_valid(lat);
        collect(res);
        want = exp_q.pop_front();
        check({name, " result"}, 64'(res), 64'(want));
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        int              lat;
        logic [XLEN-1:0] held;
        logic            seen_valid;

        vecs[0]  = '{MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT};
        vecs[1]  = '{MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT};
        vecs[2]  = '{MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT};
        vecs[3]  = '{MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT};
        vecs[4]  = '{MD_MUL,    32'h12345678, 32'd0,        32'd0,        MUL_LAT};
        vecs[5]  = '{MD_MULH,   32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MUL_LAT};
        vecs[6]  = '{MD_DIV,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, DIV_LAT};
        vecs[7]  = '{MD_REM,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, DIV_LAT};
        vecs[8]  = '{MD_DIVU,   32'd20,       32'd3,        32'd6,        DIV_LAT};
        vecs[9]  = '{MD_REMU,   32'd20,       32'd3,        32'd2,        DIV_LAT};
        vecs[10] = '{MD_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT};
        vecs[11] = '{MD_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, SPC_LAT};
        vecs[12] = '{MD_REMU,   32'd5,        32'd0,        32'd5,        SPC_LAT};
        vecs[13] = '{MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPC_LAT};
        vecs[14] = '{MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        SPC_LAT};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = MD_MUL;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        #23;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_result", 64'(out_result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < NVEC; i++) begin
            run_op($sformatf("v%0d %s", i, vecs[i].op.name()),
                   vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // Backpressure: result and ready must hold while the consumer stalls.
        start_op(MD_DIVU, 32'd100, 32'd7);
        wait_valid(lat);
        check("bp latency", 64'(lat), 64'(DIV_LAT));
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp out_result c%0d", i), 64'(out_result), 64'd14);
            check($sformatf("bp in_ready c%0d", i), 64'(in_ready), 64'd0);
            check($sformatf("bp out_valid c%0d", i), 64'(out_valid), 64'd1);
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp post in_ready", 64'(in_ready), 64'd1);
        check("bp post out_valid", 64'(out_valid), 64'd0);

        // Flush five cycles into the iterative phase.
        held = out_result;
        start_op(MD_DIVU, 32'd1000, 32'd3);
        repeat (6) @(posedge clk);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op    = MD_MUL;
        in_a     = 32'd9;
        in_b     = 32'd9;
        @(posedge clk);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush in_ready", 64'(in_ready), 64'd1);
        check("flush out_valid", 64'(out_valid), 64'd0);
        check("flush out_result held", 64'(out_result), 64'(held));
        seen_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            seen_valid = seen_valid | out_valid;
        end
        check("flush no out_valid", 64'(seen_valid), 64'd0);
        run_op("post-flush MUL", MD_MUL, 32'd6, 32'd7, 32'd42, MUL_LAT);

        // Reset asserted mid-operation takes effect without a clock edge.
        start_op(MD_DIVU, 32'd1000, 32'd3);
        repeat (6) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst mid out_valid", 64'(out_valid), 64'd0);
        check("rst mid out_result", 64'(out_result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst mid in_ready", 64'(in_ready), 64'd1);
        run_op("post-reset MUL", MD_MUL, 32'd6, 32'd7, 32'd42, MUL_LAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
